key_event_detector: RTL and testbench
=====================================

Name: key_event_detector

Overview:
- Parametrised, multi-channel front-panel key processor for the electric clock and later boards.
- Per key, it synchronises and debounces the raw active-low input.
- It classifies each press as short or long and, while a long press is held, emits auto-repeat pulses.
- Downstream time-setting logic consumes the single-cycle event pulses instead of raw key levels.

Parameters:
- N_KEY, 4, number of independent key channels (1..16)
- MCNT_DB, 1_000_000, debounce window in Clk cycles (20 ms at 50 MHz); legal >= 2
- MCNT_LONG, 100_000_000, hold time for a long press in Clk cycles (2 s); legal > MCNT_DB
- MCNT_REP, 10_000_000, auto-repeat interval in Clk cycles (200 ms); legal >= 2
- REPEAT_EN, 1, 1 enables auto-repeat after a long press; 0 gives a single Long_pulse only

Ports:
- Clk  input  1  system clock; single clock domain
- Reset_n  input  1  synchronous reset, active-low; sampled on the rising edge of Clk
- Key  input  N_KEY  raw key pins; active-low (0 = pressed); asynchronous to Clk
- Key_state  output  N_KEY  debounced level; 1 = pressed
- Short_pulse  output  N_KEY  1-cycle pulse on release of a press shorter than MCNT_LONG
- Long_pulse  output  N_KEY  1-cycle pulse when a press reaches MCNT_LONG cycles
- Repeat_pulse  output  N_KEY  1-cycle pulse every MCNT_REP cycles after Long_pulse while the key is still held

Behaviour:
- Clocking and reset:
  - All state updates on posedge Clk.
  - While Reset_n=0 at an edge:
    - synchroniser flops and the stable raw level load 1 (released);
    - all counters load 0; all FSMs go to IDLE;
    - all outputs are 0.
- Synchroniser: 2-flop per channel; the raw sample s2 lags Key by 2 cycles.
- Debounce (per channel):
  - A counter increments each cycle that s2 differs from the stable level and clears on any cycle that s2 equals it.
  - When the counter reaches MCNT_DB-1 while still differing, the stable level toggles on that edge and the counter clears.
  - Key_state = ~stable (registered).
  - Any glitch shorter than MCNT_DB cycles produces no Key_state change.
- Classification FSM (per channel, driven by Key_state):
  - IDLE: on Key_state=1, clear hold_cnt and go to PRESS.
  - PRESS: hold_cnt increments each cycle.
    - On Key_state=0: Short_pulse=1 for one cycle, then go to IDLE.
    - When hold_cnt reaches MCNT_LONG-1 with Key_state still 1: Long_pulse=1 for one cycle, clear rep_cnt, go to HELD.
  - HELD: rep_cnt increments.
    - When REPEAT_EN=1 and rep_cnt reaches MCNT_REP-1: Repeat_pulse=1 for one cycle and rep_cnt clears.
    - On Key_state=0: go to IDLE with no Short_pulse.
- Release on the exact cycle the long threshold is reached: release wins; Short_pulse fires, Long_pulse does not.
- Output timing:
  - Long_pulse rises exactly MCNT_LONG cycles after Key_state rises.
  - The first Repeat_pulse comes MCNT_REP cycles after Long_pulse, then every MCNT_REP cycles.
  - Short_pulse is asserted in the first cycle Key_state reads 0.
- Pulse exclusivity: at most one of Short/Long/Repeat is high per channel per cycle.
- Counter widths:
  - debounce counter: $clog2(MCNT_DB);
  - hold counter: $clog2(MCNT_LONG);
  - repeat counter: $clog2(MCNT_REP).
  - Counters saturate/clear as above and never wrap.
- Channel independence: channels are fully independent. Simultaneous presses on several keys each produce their own events in the same cycles.
- Reset mid-press: all events are discarded. After Reset_n returns high, a still-held key is debounced as a fresh press: Key_state rises MCNT_DB+2 to MCNT_DB+3 cycles later, and no Short_pulse is produced for the aborted press.
- No combinational path from Key to any output.

Test Plan:
(Bench parameters: N_KEY=4, MCNT_DB=4, MCNT_LONG=20, MCNT_REP=8, REPEAT_EN=1.)
1. Reset_n=0 with Key=4'b0000 for 5 cycles, then Reset_n=1 -> all outputs 0 during reset; Key_state becomes 4'b1111 within 7 cycles; no pulses in that window.
2. Key[3]=0 for 12 cycles, then 1 -> Key_state[3] high; exactly one Short_pulse[3]; zero Long_pulse/Repeat_pulse; other channels 0.
3. Key[2] bounce (0 for 2 cycles, 1 for 1 cycle, repeated 5 times), then 1 -> Key_state[2] stays 0; no pulses.
4. Key[1]=0 held 60 cycles after Key_state[1] rises -> Long_pulse[1] at +20; Repeat_pulse[1] at +28, +36, +44, +52; no Short_pulse on release.
5. Key[0] and Key[1] pressed together; Key[0] released after 10 stable cycles, Key[1] after 30 -> Short_pulse[0] only; Long_pulse[1] at +20, Repeat_pulse[1] at +28; no cross-talk between channels.
6. Key[1] held, Reset_n pulsed low 2 cycles at hold_cnt=15, key kept low -> no Short_pulse; Key_state[1] re-rises after debounce; Long_pulse[1] 20 cycles after that. Rerun with REPEAT_EN=0 -> Long_pulse only, zero Repeat_pulse.

Source files
------------

// File: rtl/key_event_detector.sv
// Per-key synchroniser, debouncer and short/long/auto-repeat press classifier for front-panel keys.
// Key_state follows Key after 2 + MCNT_DB cycles; event pulses are registered one-cycle strobes and there is no backpressure.
module key_event_detector #(
    parameter int N_KEY     = 4,
    parameter int MCNT_DB   = 1_000_000,
    parameter int MCNT_LONG = 100_000_000,
    parameter int MCNT_REP  = 10_000_000,
    parameter int REPEAT_EN = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_KEY-1:0] Key,
    output logic [N_KEY-1:0] Key_state,
    output logic [N_KEY-1:0] Short_pulse,
    output logic [N_KEY-1:0] Long_pulse,
    output logic [N_KEY-1:0] Repeat_pulse
);

    localparam int DB_W   = $clog2(MCNT_DB);
    localparam int HOLD_W = $clog2(MCNT_LONG);
    localparam int REP_W  = $clog2(MCNT_REP);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(MCNT_DB - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MCNT_LONG - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(MCNT_REP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    logic [N_KEY-1:0]  r_s1;
    logic [N_KEY-1:0]  r_s2;
    logic [N_KEY-1:0]  r_stable;
    logic [DB_W-1:0]   r_db_cnt   [N_KEY];
    logic [HOLD_W-1:0] r_hold_cnt [N_KEY];
    logic [REP_W-1:0]  r_rep_cnt  [N_KEY];
    state_t            r_state    [N_KEY];
    logic [N_KEY-1:0]  r_short;
    logic [N_KEY-1:0]  r_long;
    logic [N_KEY-1:0]  r_repeat;

    logic [N_KEY-1:0]  w_toggle;
    logic [N_KEY-1:0]  w_pressed_nxt;

    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < N_KEY; i++) begin
            w_toggle[i] = (r_s2[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
        end
    end

    // The classifier looks at the debounced level being loaded this edge, so its
    // pulses line up with the Key_state transition rather than trailing it by one.
    assign w_pressed_nxt = ~(r_stable ^ w_toggle);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_s1     <= '1;
            r_s2     <= '1;
            r_stable <= '1;
            for (int i = 0; i < N_KEY; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_s1     <= Key;
            r_s2     <= r_s1;
            r_stable <= r_stable ^ w_toggle;
            for (int i = 0; i < N_KEY; i++) begin
                if ((r_s2[i] == r_stable[i]) || w_toggle[i]) begin
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_short  <= '0;
            r_long   <= '0;
            r_repeat <= '0;
            for (int i = 0; i < N_KEY; i++) begin
                r_hold_cnt[i] <= '0;
                r_rep_cnt[i]  <= '0;
                r_state[i]    <= ST_IDLE;
            end
        end else begin
            r_short  <= '0;
            r_long   <= '0;
            r_repeat <= '0;
            for (int i = 0; i < N_KEY; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_pressed_nxt[i]) begin
                            r_hold_cnt[i] <= '0;
                            r_state[i]    <= ST_PRESS;
                        end
                    end
                    ST_PRESS: begin
                        // Release is tested first so it wins on the threshold cycle.
                        if (!w_pressed_nxt[i]) begin
                            r_short[i] <= 1'b1;
                            r_state[i] <= ST_IDLE;
                        end else if (r_hold_cnt[i] == HOLD_LAST) begin
                            r_long[i]    <= 1'b1;
                            r_rep_cnt[i] <= '0;
                            r_state[i]   <= ST_HELD;
                        end else begin
                            r_hold_cnt[i] <= r_hold_cnt[i] + HOLD_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (!w_pressed_nxt[i]) begin
                            r_state[i] <= ST_IDLE;
                        end else if (r_rep_cnt[i] == REP_LAST) begin
                            // Without auto-repeat the counter parks at its last value.
                            if (REPEAT_EN != 0) begin
                                r_repeat[i]  <= 1'b1;
                                r_rep_cnt[i] <= '0;
                            end
                        end else begin
                            r_rep_cnt[i] <= r_rep_cnt[i] + REP_W'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Key_state    = ~r_stable;
    assign Short_pulse  = r_short;
    assign Long_pulse   = r_long;
    assign Repeat_pulse = r_repeat;

endmodule

// File: tb/tb_key_event_detector.sv
// Bench for key_event_detector: two instances (auto-repeat on/off) share stimulus and are checked every cycle
// against an event-timing model, plus per-segment pulse-count tables and hand-built threshold/glitch cases.
module tb_key_event_detector;

    localparam int NK   = 4;
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 8;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] Key;
    logic [3:0] ks0, sp0, lp0, rp0;
    logic [3:0] ks1, sp1, lp1, rp1;

    key_event_detector #(
        .N_KEY(NK), .MCNT_DB(DB), .MCNT_LONG(LONG), .MCNT_REP(REP), .REPEAT_EN(1)
    ) dut_rep (
        .Clk(Clk), .Reset_n(Reset_n), .Key(Key),
        .Key_state(ks0), .Short_pulse(sp0), .Long_pulse(lp0), .Repeat_pulse(rp0)
    );

    key_event_detector #(
        .N_KEY(NK), .MCNT_DB(DB), .MCNT_LONG(LONG), .MCNT_REP(REP), .REPEAT_EN(0)
    ) dut_norep (
        .Clk(Clk), .Reset_n(Reset_n), .Key(Key),
        .Key_state(ks1), .Short_pulse(sp1), .Long_pulse(lp1), .Repeat_pulse(rp1)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: sync pipe, a sample window per key, and press start times.
    logic [3:0]  m_s1, m_s2, m_rel;
    logic [31:0] m_win    [NK];
    int          m_nwin   [NK];
    int          m_pstart [NK];
    int          m_cyc = 0;
    logic [3:0]  e_state, e_short, e_long, e_rep;

    int         c_sp [8];
    int         c_lp [8];
    int         c_rp [8];
    logic [3:0] seen;

    typedef struct {
        logic        rst_n;
        logic [3:0]  key;
        int          cyc;
        logic [3:0]  st;
        logic [15:0] es;
        logic [15:0] el;
        logic [15:0] er;
    } seg_t;

    seg_t segs [15];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b, want %b", name, m_cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, m_cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic [3:0] key);
        logic smp;
        logic was;
        logic now;
        int   age;
        m_cyc++;
        e_short = '0;
        e_long  = '0;
        e_rep   = '0;
        for (int c = 0; c < NK; c++) begin
            if (!rst_n) begin
                m_s1[c]     = 1'b1;
                m_s2[c]     = 1'b1;
                m_rel[c]    = 1'b1;
                m_nwin[c]   = 0;
                m_pstart[c] = -1;
            end else begin
                smp     = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = key[c];
                m_win[c] = {m_win[c][30:0], smp};
                if (m_nwin[c] < DB) m_nwin[c]++;
                was = ~m_rel[c];
                // The level flips once DB consecutive samples all disagree with it.
                if (m_nwin[c] == DB && m_win[c][DB-1:0] == {DB{~m_rel[c]}})
                    m_rel[c] = ~m_rel[c];
                now = ~m_rel[c];
                age = m_cyc - m_pstart[c];
                if (!was && now) begin
                    m_pstart[c] = m_cyc;
                end else if (was && !now) begin
                    if (age <= LONG) e_short[c] = 1'b1;
                end else if (was && now) begin
                    if (age == LONG) e_long[c] = 1'b1;
                    else if (age > LONG && (age - LONG) % REP == 0) e_rep[c] = 1'b1;
                end
            end
            e_state[c] = ~m_rel[c];
        end
    endtask

    task automatic tick(input logic rst_n, input logic [3:0] key);
        Reset_n = rst_n;
        Key     = key;
        @(posedge Clk);
        model_step(rst_n, key);
        #1;
        chk("key_state", ks0, e_state);
        chk("short", sp0, e_short);
        chk("long", lp0, e_long);
        chk("repeat", rp0, e_rep);
        chk("nr_key_state", ks1, e_state);
        chk("nr_short", sp1, e_short);
        chk("nr_long", lp1, e_long);
        chk("nr_repeat", rp1, 4'b0000);
        seen = seen | ks0;
        for (int c = 0; c < NK; c++) begin
            c_sp[c] += int'(sp0[c]);  c_sp[4+c] += int'(sp1[c]);
            c_lp[c] += int'(lp0[c]);  c_lp[4+c] += int'(lp1[c]);
            c_rp[c] += int'(rp0[c]);  c_rp[4+c] += int'(rp1[c]);
        end
    endtask

    task automatic run(input logic rst_n, input logic [3:0] key, input int n);
        for (int k = 0; k < n; k++) tick(rst_n, key);
    endtask

    task automatic clr;
        for (int i = 0; i < 8; i++) begin
            c_sp[i] = 0;
            c_lp[i] = 0;
            c_rp[i] = 0;
        end
        seen = '0;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] es, input logic [15:0] el,
                                input logic [15:0] er);
        for (int c = 0; c < NK; c++) begin
            chk_int($sformatf("%s short[%0d]", tag, c), c_sp[c], int'(es[c*4 +: 4]));
            chk_int($sformatf("%s long[%0d]", tag, c), c_lp[c], int'(el[c*4 +: 4]));
            chk_int($sformatf("%s repeat[%0d]", tag, c), c_rp[c], int'(er[c*4 +: 4]));
            chk_int($sformatf("%s nr_short[%0d]", tag, c), c_sp[4+c], int'(es[c*4 +: 4]));
            chk_int($sformatf("%s nr_long[%0d]", tag, c), c_lp[4+c], int'(el[c*4 +: 4]));
            chk_int($sformatf("%s nr_repeat[%0d]", tag, c), c_rp[4+c], 0);
        end
    endtask

    initial begin
        logic       r;
        logic [3:0] kv;
        int         n;

        //           rst   key      cyc  state    short    long     repeat
        segs[0]  = '{1'b0, 4'b0000,  5, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        segs[1]  = '{1'b1, 4'b0000,  8, 4'b1111, 16'h0000, 16'h0000, 16'h0000};
        segs[2]  = '{1'b1, 4'b1111, 12, 4'b0000, 16'h1111, 16'h0000, 16'h0000};
        segs[3]  = '{1'b1, 4'b0111, 12, 4'b1000, 16'h0000, 16'h0000, 16'h0000};
        segs[4]  = '{1'b1, 4'b1111, 12, 4'b0000, 16'h1000, 16'h0000, 16'h0000};
        segs[5]  = '{1'b1, 4'b1101, 56, 4'b0010, 16'h0000, 16'h0010, 16'h0030};
        segs[6]  = '{1'b1, 4'b1111, 12, 4'b0000, 16'h0000, 16'h0000, 16'h0010};
        segs[7]  = '{1'b1, 4'b1100, 10, 4'b0011, 16'h0000, 16'h0000, 16'h0000};
        segs[8]  = '{1'b1, 4'b1101, 20, 4'b0010, 16'h0001, 16'h0010, 16'h0000};
        segs[9]  = '{1'b1, 4'b1111, 12, 4'b0000, 16'h0000, 16'h0000, 16'h0010};
        segs[10] = '{1'b1, 4'b1101, 21, 4'b0010, 16'h0000, 16'h0000, 16'h0000};
        segs[11] = '{1'b0, 4'b1101,  2, 4'b0000, 16'h0000, 16'h0000, 16'h0000};
        segs[12] = '{1'b1, 4'b1101, 30, 4'b0010, 16'h0000, 16'h0010, 16'h0000};
        segs[13] = '{1'b1, 4'b1101, 12, 4'b0010, 16'h0000, 16'h0000, 16'h0020};
        segs[14] = '{1'b1, 4'b1111, 12, 4'b0000, 16'h0000, 16'h0000, 16'h0000};

        Reset_n = 1'b0;
        Key     = 4'b1111;

        for (int s = 0; s < 15; s++) begin
            clr();
            run(segs[s].rst_n, segs[s].key, segs[s].cyc);
            chk($sformatf("seg%0d end_state", s), ks0, segs[s].st);
            check_counts($sformatf("seg%0d", s), segs[s].es, segs[s].el, segs[s].er);
        end

        // Bounce on key 2: never four equal samples in a row.
        clr();
        for (int k = 0; k < 5; k++) begin
            run(1'b1, 4'b1011, 2);
            run(1'b1, 4'b1111, 1);
        end
        run(1'b1, 4'b1111, 10);
        chk("bounce state_seen", seen, 4'b0000);
        check_counts("bounce", 16'h0000, 16'h0000, 16'h0000);

        // Glitch one cycle shorter than the window, then exactly the window.
        clr();
        run(1'b1, 4'b1110, DB - 1);
        run(1'b1, 4'b1111, 10);
        chk("glitch_short state_seen", seen, 4'b0000);
        run(1'b1, 4'b1110, DB);
        run(1'b1, 4'b1111, 10);
        chk("glitch_exact state_seen", seen, 4'b0001);
        check_counts("glitch", 16'h0001, 16'h0000, 16'h0000);

        // Release on the exact long threshold: short wins.
        clr();
        run(1'b1, 4'b1110, LONG);
        run(1'b1, 4'b1111, 12);
        check_counts("thr_eq", 16'h0001, 16'h0000, 16'h0000);

        // One cycle past the threshold: long, no short, no repeat yet.
        clr();
        run(1'b1, 4'b1110, LONG + 1);
        run(1'b1, 4'b1111, 12);
        check_counts("thr_gt", 16'h0000, 16'h0001, 16'h0000);

        for (int k = 0; k < 80; k++) begin
            r  = ($urandom_range(0, 24) != 0);
            kv = 4'($urandom);
            n  = r ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 3));
            run(r, kv, n);
        end
        run(1'b1, 4'b1111, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
